// File: rtl/tri_pack_pkg.sv
// Shared types and sizing helpers for the triangular-pack loader.
// tri_base(ch) is the first packed slot of channel ch; tri_width gives the packed width.
package tri_pack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int tri_base(input int ch);
    return (ch * (ch + 1)) / 2;
  endfunction

  function automatic int tri_width(input int n, input int w);
    return w * ((n * (n + 1)) / 2);
  endfunction

  function automatic int tri_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tri_idx_w(input int n);
    return (tri_base(n) > 1) ? $clog2(tri_base(n)) : 1;
  endfunction

endpackage

// File: rtl/tri_pack_loader_if.sv
// Control, element and result signals of the triangular-pack loader.
// master drives the fill; slave is the loader itself.
interface tri_pack_loader_if
  import tri_pack_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 1
);
  localparam int TOT = tri_width(N, W);

  logic           start;
  logic           abort;
  logic           mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           s_valid;
  logic [W-1:0]   s_data;
  logic           s_ready;
  logic           busy;
  logic           done;
  logic           o_valid;
  logic [TOT-1:0] o;

  modport master (
    output start, abort, mode, a, b, s_valid, s_data,
    input  s_ready, busy, done, o_valid, o
  );

  modport slave (
    input  start, abort, mode, a, b, s_valid, s_data,
    output s_ready, busy, done, o_valid, o
  );

endinterface

// File: rtl/tri_index_counter.sv
// Channel/element counters for the triangular walk; idx is the linear packed slot
// and last flags the final element of the final channel.
module tri_index_counter
  import tri_pack_pkg::*;
#(
  parameter  int N  = 4,
  localparam int CW = tri_cnt_w(N),
  localparam int IW = tri_idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic          ch_odd,
  output logic          last,
  output logic [IW-1:0] idx
);

  logic [CW-1:0] ch_r;
  logic [CW-1:0] e_r;

  // Step e through 0..ch, then move to the next channel.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ch_r <= {CW{1'b0}};
      e_r  <= {CW{1'b0}};
    end else if (advance) begin
      if (e_r == ch_r) begin
        ch_r <= ch_r + CW'(1'b1);
        e_r  <= {CW{1'b0}};
      end else begin
        e_r  <= e_r + CW'(1'b1);
      end
    end
  end

  assign ch_odd = ch_r[0];
  assign last   = (ch_r == CW'(N - 1)) && (e_r == ch_r);
  assign idx    = IW'(tri_base(int'(ch_r)) + int'(e_r));

endmodule

// File: rtl/tri_pack_loader.sv
// Sequential triangular packer: fills N channels (channel i holds i+1 elements)
// from a replicate source or a serial stream, then pulses done.
module tri_pack_loader
  import tri_pack_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 1
) (
  input logic              clk,
  input logic              rst,
  tri_pack_loader_if.slave bus
);

  localparam int TOT = tri_width(N, W);
  localparam int IW  = tri_idx_w(N);

  state_e         state_r;
  logic           mode_r;
  logic [TOT-1:0] o_r;
  logic           o_valid_r;
  logic           done_r;
  logic           busy_r;

  logic           accept_s;
  logic           advance_s;
  logic           clear_s;
  logic           ch_odd_s;
  logic           last_s;
  logic [IW-1:0]  idx_s;
  logic [W-1:0]   elem_s;

  // An accept that coincides with abort is dropped, so the counters never move on it.
  always_comb begin
    accept_s = 1'b0;
    if (state_r == FILL) begin
      accept_s = !mode_r || bus.s_valid;
    end else begin
      accept_s = 1'b0;
    end
  end

  assign advance_s = accept_s && !bus.abort;
  assign clear_s   = (state_r != FILL) || bus.abort;

  // Element source: serial data, or a/b chosen by channel parity, sampled live.
  always_comb begin
    elem_s = {W{1'b0}};
    if (mode_r) begin
      elem_s = bus.s_data;
    end else if (ch_odd_s) begin
      elem_s = bus.b;
    end else begin
      elem_s = bus.a;
    end
  end

  tri_index_counter #(.N(N)) u_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear_s),
    .advance (advance_s),
    .ch_odd  (ch_odd_s),
    .last    (last_s),
    .idx     (idx_s)
  );

  // Control FSM with registered status outputs and the packed result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      mode_r    <= 1'b0;
      o_r       <= {TOT{1'b0}};
      o_valid_r <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            mode_r    <= bus.mode;
            o_r       <= {TOT{1'b0}};
            o_valid_r <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= FILL;
          end
        end
        FILL: begin
          if (bus.abort) begin
            o_r       <= {TOT{1'b0}};
            o_valid_r <= 1'b0;
            busy_r    <= 1'b0;
            state_r   <= IDLE;
          end else if (accept_s) begin
            o_r[int'(idx_s) * W +: W] <= elem_s;
            if (last_s) begin
              done_r    <= 1'b1;
              o_valid_r <= 1'b1;
              state_r   <= DONE;
            end
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
          if (bus.abort) begin
            o_r       <= {TOT{1'b0}};
            o_valid_r <= 1'b0;
          end
        end
        default: begin
          o_r       <= {TOT{1'b0}};
          o_valid_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign bus.s_ready = (state_r == FILL) && mode_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.o_valid = o_valid_r;
  assign bus.o       = o_r;

endmodule

// File: tb/tb_tri_pack_loader.sv
// Scoreboard bench for tri_pack_loader: N=4/W=1 and N=3/W=2 instances, directed fills,
// with a done-triggered monitor comparing result and completion cycle against a queue.
module tb_tri_pack_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tri_pack_loader_if #(.N(4), .W(1)) if4 ();
  tri_pack_loader_if #(.N(3), .W(2)) if3 ();

  tri_pack_loader #(.N(4), .W(1)) u4 (.clk(clk), .rst(rst), .bus(if4));
  tri_pack_loader #(.N(3), .W(2)) u3 (.clk(clk), .rst(rst), .bus(if3));

  typedef struct {
    logic [31:0] o;
    int          at;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input bit sel);
    logic b;
    b = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step();
      b = sel ? if3.busy : if4.busy;
      if (!b) break;
    end
    check(sel ? "n3 returns idle" : "n4 returns idle", 32'(b), 32'd0);
  endtask

  // Monitor: every done pulse pops one expected result and checks it.
  always @(negedge clk) begin
    exp_t x;
    if (if4.done === 1'b1) begin
      if (q4.size() == 0) begin
        check("n4 unexpected done", 32'(if4.done), 32'd0);
      end else begin
        x = q4.pop_front();
        check("n4 o at done", 32'(if4.o), x.o);
        check("n4 o_valid at done", 32'(if4.o_valid), 32'd1);
        check("n4 done cycle", 32'(cyc), 32'(x.at));
      end
    end
    if (if3.done === 1'b1) begin
      if (q3.size() == 0) begin
        check("n3 unexpected done", 32'(if3.done), 32'd0);
      end else begin
        x = q3.pop_front();
        check("n3 o at done", 32'(if3.o), x.o);
        check("n3 o_valid at done", 32'(if3.o_valid), 32'd1);
        check("n3 done cycle", 32'(cyc), 32'(x.at));
      end
    end
  end

  initial begin
    rst = 1'b1;
    {if4.start, if4.abort, if4.mode, if4.a, if4.b, if4.s_valid, if4.s_data} = '0;
    {if3.start, if3.abort, if3.mode, if3.a, if3.b, if3.s_valid, if3.s_data} = '0;
    repeat (3) step();
    @(negedge clk);
    check("reset busy", 32'(if4.busy), 32'd0);
    check("reset done", 32'(if4.done), 32'd0);
    check("reset o_valid", 32'(if4.o_valid), 32'd0);
    check("reset o", 32'(if4.o), 32'd0);
    check("reset s_ready", 32'(if4.s_ready), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Replicate a=1, b=0
    if4.mode = 1'b0; if4.a = 1'b1; if4.b = 1'b0; if4.start = 1'b1;
    q4.push_back('{32'h039, cyc + 11});
    step();
    if4.start = 1'b0;
    @(negedge clk);
    check("n4 busy in fill", 32'(if4.busy), 32'd1);
    check("n4 s_ready replicate", 32'(if4.s_ready), 32'd0);
    wait_idle(1'b0);
    @(negedge clk);
    check("n4 o after rep1", 32'(if4.o), 32'h039);
    check("n4 o_valid after rep1", 32'(if4.o_valid), 32'd1);

    // Replicate a=0, b=1
    if4.a = 1'b0; if4.b = 1'b1; if4.start = 1'b1;
    q4.push_back('{32'h3C6, cyc + 11});
    step();
    if4.start = 1'b0;
    wait_idle(1'b0);
    @(negedge clk);
    check("n4 o after rep2", 32'(if4.o), 32'h3C6);

    // Restart clears o_valid and o, then abort at FILL cycle 5
    if4.a = 1'b1; if4.b = 1'b1; if4.start = 1'b1;
    step();
    if4.start = 1'b0;
    @(negedge clk);
    check("n4 o_valid cleared by restart", 32'(if4.o_valid), 32'd0);
    check("n4 o cleared by restart", 32'(if4.o), 32'd0);
    repeat (4) step();
    if4.abort = 1'b1;
    step();
    if4.abort = 1'b0;
    @(negedge clk);
    check("n4 busy after abort", 32'(if4.busy), 32'd0);
    check("n4 o after abort", 32'(if4.o), 32'd0);
    check("n4 o_valid after abort", 32'(if4.o_valid), 32'd0);
    repeat (15) step();
    check("n4 o_valid stays low", 32'(if4.o_valid), 32'd0);

    // start together with abort is ignored
    if4.start = 1'b1; if4.abort = 1'b1;
    step();
    if4.start = 1'b0; if4.abort = 1'b0;
    @(negedge clk);
    check("n4 start+abort idle", 32'(if4.busy), 32'd0);
    step();

    // Serial stream k%2, continuous valid; mode dropped mid-fill must not matter
    if4.mode = 1'b1; if4.start = 1'b1;
    q4.push_back('{32'h2AA, cyc + 11});
    step();
    if4.start = 1'b0; if4.mode = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if4.s_valid = 1'b1; if4.s_data = 1'(k % 2);
      step();
    end
    if4.s_valid = 1'b0;
    wait_idle(1'b0);
    @(negedge clk);
    check("n4 o after serial", 32'(if4.o), 32'h2AA);

    // Serial stream with a 3-cycle valid gap
    if4.mode = 1'b1; if4.start = 1'b1;
    q4.push_back('{32'h2AA, cyc + 14});
    step();
    if4.start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin
        for (int g = 0; g < 3; g++) begin
          if4.s_valid = 1'b0; if4.s_data = 1'((k + 1) % 2);
          @(negedge clk);
          check("n4 s_ready during stall", 32'(if4.s_ready), 32'd1);
          step();
        end
      end
      if4.s_valid = 1'b1; if4.s_data = 1'(k % 2);
      @(negedge clk);
      check("n4 s_ready in fill", 32'(if4.s_ready), 32'd1);
      step();
    end
    if4.s_valid = 1'b0;
    wait_idle(1'b0);
    @(negedge clk);
    check("n4 o after stalled serial", 32'(if4.o), 32'h2AA);

    // N=3, W=2 replicate
    if3.mode = 1'b0; if3.a = 2'b01; if3.b = 2'b10; if3.start = 1'b1;
    q3.push_back('{32'h569, cyc + 7});
    step();
    if3.start = 1'b0;
    wait_idle(1'b1);
    @(negedge clk);
    check("n3 o after rep", 32'(if3.o), 32'h569);
    check("n3 o_valid after rep", 32'(if3.o_valid), 32'd1);

    // Reset in the middle of a fill
    if3.start = 1'b1;
    step();
    if3.start = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("n3 busy after rst", 32'(if3.busy), 32'd0);
    check("n3 o after rst", 32'(if3.o), 32'd0);
    check("n3 o_valid after rst", 32'(if3.o_valid), 32'd0);
    check("n3 s_ready after rst", 32'(if3.s_ready), 32'd0);
    check("n3 done after rst", 32'(if3.done), 32'd0);
    check("n4 o_valid after rst", 32'(if4.o_valid), 32'd0);
    rst = 1'b0;
    repeat (12) step();

    check("n4 queue drained", 32'(q4.size()), 32'd0);
    check("n3 queue drained", 32'(q3.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tri_pack_loader.md
# tri_pack_loader

Sequential, parametrised successor to the combinational triangular packer. Fills N channel groups, where channel i holds i+1 elements of W bits, one element per accepted cycle, into a triangular-packed output vector. Elements come from either a replicate source (a for even channels, b for odd) or a serial valid/ready stream. Completion is signalled with a done pulse. It sits between the control sequencer and downstream logic that consumes the packed vector.

## Interface
- N, 4: channel count, 1..16
- W, 1: element width in bits, 1..32
- TOT (localparam): W*N*(N+1)/2, output width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a fill; sampled only in IDLE
- abort  in  1  cancel the current fill; return to IDLE
- mode  in  1  0 = replicate (a/b), 1 = serial stream; latched at start
- a  in  W  element value for even channels (replicate mode)
- b  in  W  element value for odd channels (replicate mode)
- s_valid  in  1  serial element valid
- s_data  in  W  serial element
- s_ready  out  1  high in FILL when the latched mode is 1
- busy  out  1  high in FILL and DONE
- done  out  1  one-cycle pulse on completion
- o_valid  out  1  o holds a complete fill; high from DONE until the next start or abort
- o  out  TOT  packed result; channel ch, element e at bits [W*(ch*(ch+1)/2+e) +: W]

## Operation
- States are IDLE, FILL and DONE.
- IDLE:
  - start=1 and abort=0: latch mode, clear o to 0, set o_valid=0, ch=0, e=0, go to FILL.
  - abort=1 overrides start.
- FILL: an element is accepted when mode_q=0 (every cycle) or s_valid&&s_ready.
  - Accepted value: replicate gives a if ch is even, else b. Both are sampled live on the accept cycle. Serial gives s_data.
  - Write the value to the slot for (ch, e).
  - If e==ch: ch+=1, e=0. Otherwise e+=1.
  - The accept at ch==N-1, e==N-1 transitions to DONE.
- DONE: done=1, o_valid set to 1, next state IDLE. The next start is accepted in IDLE at the earliest, never in DONE.
- abort in FILL or DONE:
  - Next state IDLE; o_valid=0; o cleared to 0; no done pulse.
  - An accept in the same cycle is discarded.
- start while busy is ignored.
- Slot offset is base(ch)+e with base(ch)=ch*(ch+1)/2. This equals the running element index k, 0..N(N+1)/2-1.
- Counter width: clog2(N), minimum 1 bit.
- mode, a and b changes during FILL:
  - mode changes have no effect, because mode is latched.
  - a and b changes take effect on the next accept.
- Reset values: state=IDLE, o=0, o_valid=0, done=0, busy=0, s_ready=0, ch=0, e=0.

## Timing
- start in cycle t moves to FILL at t+1.
- Replicate mode: FILL lasts exactly N(N+1)/2 cycles, so done is high at cycle t+1+N(N+1)/2. That is t+11 for N=4.
- Serial mode: done is high one cycle after the final handshake. Each stall cycle adds one cycle.
- s_ready is combinational from the state and mode_q only, never from s_valid.
- o updates on the clock edge following each accept. It is stable and complete when o_valid=1.
- rst mid-fill: all outputs take their reset values on the next edge.

## Structure
- Package tri_pack_pkg holds:
  - state enum (IDLE, FILL, DONE)
  - function tri_base(ch)
  - function tri_width(N, W) returning TOT
- Sub-module tri_index_counter holds the ch/e counters and the last-element flag, and outputs the linear slot index.
- The top level holds the FSM, the element mux and the packed register.

## Test plan
- N=4, W=1, mode=0, a=1, b=0, start pulse: done at start+11, o=10'h039, o_valid=1.
- N=4, W=1, mode=0, a=0, b=1: o=10'h3C6. Then a second start clears o_valid on the next cycle, and o reads 0 during the fill.
- N=4, W=1, mode=1, stream bits k%2 for k=0..9 with s_valid continuous: o=10'h2AA, done at start+11.
- Same stream with s_valid low for 3 cycles mid-fill: done at start+14, o=10'h2AA, s_ready high throughout FILL.
- Abort at FILL cycle 5: state IDLE, o=0, o_valid=0, no done. start and abort in the same cycle: FSM stays in IDLE.
- N=3, W=2, mode=0, a=2'b01, b=2'b10: o=12'b010101101001 (0x569), done at start+7. Assert rst mid-fill: all outputs return to zero on the next edge.
